// File: rtl/al_accel_pkg.sv
// Shared constants and types for the 2x2 pooling stream accelerator.
package al_accel_pkg;

  // Pooling mode encoding carried on cfg_mode.
  localparam logic POOL_MAX = 1'b0;
  localparam logic POOL_AVG = 1'b1;

  // Frame sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/al_accel_pool_cmp2.sv
// Two-operand pooling combiner: signed max, or full-precision sum.
// The result is one bit wider than the operands so a sum never overflows.
module al_accel_pool_cmp2
  import al_accel_pkg::*;
#(
  parameter int W = 8
) (
  input  logic                mode,
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W:0]   y
);

  // Select the larger operand (sign-extended) or add both operands.
  always_comb begin
    y = '0;
    if (mode == POOL_MAX) begin
      y = (a > b) ? {a[W-1], a} : {b[W-1], b};
    end else begin
      y = {a[W-1], a} + {b[W-1], b};
    end
  end

endmodule

// File: rtl/al_accel_pool_stream.sv
// Streaming 2x2 max/average pooling over a raster-order pixel stream.
// Row pairs are folded with a half-width line buffer: even rows store the
// horizontal pair result, odd rows combine it with the stored value.
//
// Handshake: a beat transfers on a rising clk edge when valid & ready are both
// high; a producer holds valid and data stable until that edge. in_ready is
// only offered while the output register is free or draining this cycle, so
// no skid storage is needed.
module al_accel_pool_stream
  import al_accel_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int MAX_COLS = 32,
  parameter int MAX_ROWS = 32
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic                              enb,
  input  logic                              start,
  input  logic [$clog2(MAX_COLS+1)-1:0]     cfg_cols,
  input  logic [$clog2(MAX_ROWS+1)-1:0]     cfg_rows,
  input  logic                              cfg_mode,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [DATA_W-1:0]                 in_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [DATA_W-1:0]                 out_data,
  output logic                              busy,
  output logic                              done,
  output state_t                            dbg_state
);

  localparam int CW       = $clog2(MAX_COLS+1);
  localparam int RW       = $clog2(MAX_ROWS+1);
  localparam int LBW      = (MAX_COLS > 2) ? $clog2(MAX_COLS/2) : 1;
  localparam int LB_DEPTH = 1 << LBW;

  state_t                   state, state_nxt;
  logic [CW-1:0]            col, cols_q;
  logic [RW-1:0]            row, rows_q;
  logic                     mode_q;
  logic signed [DATA_W-1:0] pair_q;
  logic signed [DATA_W:0]   line_buf [LB_DEPTH];
  logic signed [DATA_W:0]   pair_res;
  logic signed [DATA_W+1:0] win_res;
  logic [DATA_W-1:0]        win_out;
  logic [LBW-1:0]           lb_idx;
  logic                     accept, col_last, row_last, last_beat, start_ok, emit;

  assign in_ready  = enb & (state == ST_RUN) & ~(out_valid & ~out_ready);
  assign accept    = in_valid & in_ready;
  assign col_last  = (col == cols_q - CW'(1));
  assign row_last  = (row == rows_q - RW'(1));
  assign last_beat = accept & col_last & row_last;
  assign start_ok  = enb & start & (state == ST_IDLE);
  assign emit      = accept & row[0] & col[0];
  assign lb_idx    = col[LBW:1];
  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;
  // Average is the 4-pixel sum shifted right by 2 (floor); max fits as-is.
  assign win_out   = (mode_q == POOL_AVG) ? win_res[DATA_W+1:2] : win_res[DATA_W-1:0];

  al_accel_pool_cmp2 #(.W(DATA_W)) u_pair (
    .mode (mode_q),
    .a    (pair_q),
    .b    (in_data),
    .y    (pair_res)
  );

  al_accel_pool_cmp2 #(.W(DATA_W+1)) u_win (
    .mode (mode_q),
    .a    (line_buf[lb_idx]),
    .b    (pair_res),
    .y    (win_res)
  );

  // Next-state and end-of-frame pulse.
  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    case (state)
      ST_IDLE:  if (start_ok) state_nxt = ST_RUN;
      ST_RUN:   if (last_beat) state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (enb && !out_valid) begin
          state_nxt = ST_IDLE;
          done      = 1'b1;
        end
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State register; enb low freezes the sequencer.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else if (enb) state <= state_nxt;
  end

  // Config capture, raster counters and the registered output beat.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cols_q    <= '0;
      rows_q    <= '0;
      mode_q    <= POOL_MAX;
      col       <= '0;
      row       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (enb) begin
      if (start_ok) begin
        cols_q <= cfg_cols;
        rows_q <= cfg_rows;
        mode_q <= cfg_mode;
        col    <= '0;
        row    <= '0;
      end else if (accept) begin
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
      if (emit) begin
        out_valid <= 1'b1;
        out_data  <= win_out;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Pair register and line buffer; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (accept) begin
      if (!col[0]) pair_q <= in_data;
      else if (!row[0]) line_buf[lb_idx] <= pair_res;
    end
  end

endmodule

// File: tb/tb_al_accel_pool_stream.sv
// Directed bench for al_accel_pool_stream with a frame-level pooling model.
module tb_al_accel_pool_stream;
  import al_accel_pkg::*;

  localparam int DATA_W   = 8;
  localparam int MAX_COLS = 32;
  localparam int MAX_ROWS = 32;
  localparam int CW       = $clog2(MAX_COLS+1);
  localparam int RW       = $clog2(MAX_ROWS+1);

  logic              clk, resetn, enb, start, cfg_mode;
  logic [CW-1:0]     cfg_cols;
  logic [RW-1:0]     cfg_rows;
  logic              in_valid, in_ready, out_valid, out_ready, busy, done;
  logic [DATA_W-1:0] in_data, out_data;
  state_t            dbg_state;

  int                n_checks = 0;
  int                n_fail   = 0;
  int                done_cnt = 0;
  logic [DATA_W-1:0] exp_q[$];
  int                pix[$];
  bit                stall_chk = 0;
  logic [DATA_W-1:0] held;

  al_accel_pool_stream #(.DATA_W(DATA_W), .MAX_COLS(MAX_COLS), .MAX_ROWS(MAX_ROWS)) dut (
    .clk(clk), .resetn(resetn), .enb(enb), .start(start),
    .cfg_cols(cfg_cols), .cfg_rows(cfg_rows), .cfg_mode(cfg_mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int sx(input logic [DATA_W-1:0] v);
    return int'($signed(v));
  endfunction

  // Frame-level model: every complete 2x2 window in raster order.
  task automatic model_frame(input int cols, input int rows, input bit mode);
    for (int pr = 0; pr + 1 < rows; pr += 2) begin
      for (int pc = 0; pc + 1 < cols; pc += 2) begin
        int a, b, c, d, v;
        a = pix[pr*cols + pc];
        b = pix[pr*cols + pc + 1];
        c = pix[(pr+1)*cols + pc];
        d = pix[(pr+1)*cols + pc + 1];
        if (mode) v = (a + b + c + d) >>> 2;
        else begin
          v = a;
          if (b > v) v = b;
          if (c > v) v = c;
          if (d > v) v = d;
        end
        exp_q.push_back(DATA_W'(v));
      end
    end
  endtask

  // Scoreboard: check every consumed beat and output stability under stall.
  always @(negedge clk) begin
    if (!resetn) begin
      stall_chk = 0;
    end else begin
      if (stall_chk) begin
        check("hold_valid", int'(out_valid), 1);
        check("hold_data", int'(out_data), int'(held));
      end
      if (out_valid && !out_ready) check("stall_in_ready", int'(in_ready), 0);
      if (out_valid && out_ready && enb) begin
        if (exp_q.size() == 0) check("extra_output", sx(out_data), 9999);
        else check("out_data", sx(out_data), sx(exp_q.pop_front()));
      end
      stall_chk = out_valid && !(out_ready && enb);
      held      = out_data;
      if (done) done_cnt++;
    end
  end

  // Driver tasks: all called at #1 after a rising edge.
  task automatic start_frame(input int cols, input int rows, input bit mode);
    cfg_cols = CW'(cols);
    cfg_rows = RW'(rows);
    cfg_mode = mode;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
  endtask

  task automatic drive_pix(input int v);
    int  k;
    bit  ok;
    in_valid = 1'b1;
    in_data  = DATA_W'(v);
    k  = 0;
    ok = 0;
    while (!ok && k < 200) begin
      @(negedge clk);
      if (in_ready) ok = 1;
      else k++;
    end
    if (!ok) check("in_ready_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic freeze3();
    enb = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("frz_in_ready", int'(in_ready), 0);
      check("frz_busy", int'(busy), 1);
    end
    @(posedge clk); #1;
    enb = 1'b1;
  endtask

  task automatic backpressure5();
    int k = 0;
    while (!out_valid && k < 500) begin
      @(posedge clk); #1;
      k++;
    end
    if (!out_valid) check("bp_first_out", 0, 1);
    out_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1 out_ready = 1'b1;
  endtask

  task automatic run_frame(input int cols, input int rows, input bit mode,
                           input int gap_at, input bit bp);
    int k;
    done_cnt = 0;
    start_frame(cols, rows, mode);
    check("busy_run", int'(busy), 1);
    if (bp) fork backpressure5(); join_none
    for (int i = 0; i < cols*rows; i++) begin
      drive_pix(pix[i]);
      if (i == gap_at) freeze3();
    end
    in_valid = 1'b0;
    k = 0;
    while (!done && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("done_seen", int'(done), 1);
    repeat (3) @(posedge clk);
    #1;
    check("done_once", done_cnt, 1);
    check("exp_left", exp_q.size(), 0);
    check("busy_idle", int'(busy), 0);
  endtask

  task automatic fill_ramp(input int n);
    pix.delete();
    for (int i = 0; i < n; i++) pix.push_back(i);
  endtask

  // Stimulus sequence.
  initial begin
    int rowp[4];
    rowp = '{-8, -4, 4, 8};
    resetn = 1'b0; enb = 1'b1; start = 1'b0; cfg_mode = 1'b0;
    cfg_cols = '0; cfg_rows = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_in_ready", int'(in_ready), 0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    @(posedge clk); #1;

    // 4x4 max, ramp.
    fill_ramp(16);
    model_frame(4, 4, 0);
    check("pin_a0", sx(exp_q[0]), 5);
    check("pin_a3", sx(exp_q[3]), 15);
    run_frame(4, 4, 0, -1, 0);

    // 4x4 avg, with an enable gap right after the first window completes.
    pix.delete();
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) pix.push_back(rowp[c]);
    model_frame(4, 4, 1);
    check("pin_b0", sx(exp_q[0]), -6);
    check("pin_b1", sx(exp_q[1]), 6);
    run_frame(4, 4, 1, 5, 0);

    // 4x2 max at signed extremes.
    pix.delete();
    for (int i = 0; i < 8; i++) pix.push_back(i == 7 ? 127 : -128);
    model_frame(4, 2, 0);
    check("pin_c0", sx(exp_q[0]), -128);
    check("pin_c1", sx(exp_q[1]), 127);
    run_frame(4, 2, 0, -1, 0);

    // 4x4 max under output backpressure.
    fill_ramp(16);
    model_frame(4, 4, 0);
    run_frame(4, 4, 0, -1, 1);

    // 5x5 max: trailing row and column discarded.
    fill_ramp(25);
    model_frame(5, 5, 0);
    check("pin_d_n", exp_q.size(), 4);
    check("pin_d0", sx(exp_q[0]), 6);
    check("pin_d3", sx(exp_q[3]), 18);
    run_frame(5, 5, 0, -1, 0);

    // Reset mid-frame, then a clean frame.
    start_frame(4, 4, 0);
    for (int i = 0; i < 5; i++) drive_pix(i);
    in_valid = 1'b0;
    resetn   = 1'b0;
    #1;
    check("mid_rst_valid", int'(out_valid), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_state", int'(dbg_state), int'(ST_IDLE));
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    fill_ramp(16);
    model_frame(4, 4, 0);
    run_frame(4, 4, 0, -1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
